// File: rtl/easy_fifo_axis_arb.sv
// Round-robin N-to-1 AXI-Stream arbiter feeding one AXIS FIFO write port.
// A grant is held for a whole packet (tlast) and/or a bounded burst, and the
// output is a registered slice that also carries the source index on tid.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   s_axis_tdata          NUM_IN*DWIDTH flattened requester data
//   s_axis_tvalid/tlast   per-requester valid / last
//   s_axis_tready         per-requester ready, one-hot or zero
//   m_axis_tdata/tvalid/tlast/tid   registered output beat
//   m_axis_tready         downstream FIFO ready
//   grant_active          high while a grant is held
module easy_fifo_axis_arb #(
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned HAS_LAST  = 1,
    parameter int unsigned MAX_BURST = 0,
    localparam int unsigned IDW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*DWIDTH-1:0] s_axis_tdata,
    input  logic [NUM_IN-1:0]        s_axis_tvalid,
    input  logic [NUM_IN-1:0]        s_axis_tlast,
    output logic [NUM_IN-1:0]        s_axis_tready,
    output logic [DWIDTH-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic [IDW-1:0]           m_axis_tid,
    input  logic                     m_axis_tready,
    output logic                     grant_active
);

    localparam int unsigned BCW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    // Without tlast and without a burst bound a grant could never end.
    if (MAX_BURST == 0 && HAS_LAST == 0) begin : g_bad_release_cfg
        $error("easy_fifo_axis_arb: MAX_BURST=0 requires HAS_LAST=1");
    end
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("easy_fifo_axis_arb: NUM_IN must be 2..16");
    end

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             state_q;
    logic [IDW-1:0]     grant_q;
    logic [IDW-1:0]     rr_q;
    logic [BCW-1:0]     beat_cnt_q;
    logic               tvalid_q;
    logic [DWIDTH-1:0]  tdata_q;
    logic               tlast_q;
    logic [IDW-1:0]     tid_q;

    logic [IDW-1:0]     grant_d;
    logic               found;
    logic               sel_valid;
    logic               sel_last;
    logic [DWIDTH-1:0]  sel_data;
    logic               out_free;
    logic               accept;
    logic               burst_end;
    logic               rel_beat;

    // Round-robin pick: first valid requester scanning upward from rr_q+1.
    always_comb begin
        grant_d = rr_q;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            if (!found &&
                ((s_axis_tvalid & (NUM_IN'(1) << ((32'(rr_q) + k) % NUM_IN))) != '0)) begin
                grant_d = IDW'((32'(rr_q) + k) % NUM_IN);
                found   = 1'b1;
            end
        end
    end

    // Mux of the currently granted requester.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign out_free  = !tvalid_q || m_axis_tready;
    assign accept    = (state_q == ST_BUSY) && sel_valid && out_free;
    assign burst_end = (MAX_BURST != 0) && ((32'(beat_cnt_q) + 32'd1) == MAX_BURST);
    assign rel_beat  = accept && (((HAS_LAST != 0) && sel_last) || burst_end);

    assign s_axis_tready = ((state_q == ST_BUSY) && out_free) ? (NUM_IN'(1) << grant_q) : '0;

    // Arbitration FSM and output register slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_q       <= IDW'(NUM_IN - 1);
            beat_cnt_q <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            tid_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                    end
                    if (s_axis_tvalid != '0) begin
                        grant_q    <= grant_d;
                        rr_q       <= grant_d;
                        beat_cnt_q <= '0;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept) begin
                        tvalid_q   <= 1'b1;
                        tdata_q    <= sel_data;
                        tlast_q    <= (HAS_LAST != 0) && sel_last;
                        tid_q      <= grant_q;
                        beat_cnt_q <= beat_cnt_q + BCW'(1);
                        if (rel_beat) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = tid_q;
    assign grant_active  = (state_q == ST_BUSY);

endmodule
